// File: rtl/game_pkg.sv
// Shared definitions for the slime game controller: state encoding,
// parameter defaults and score bound.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_HURT  = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam int unsigned LIVES_INIT_DEF       = 3;
  localparam int unsigned TICKS_PER_POINT_DEF  = 64;
  localparam int unsigned POINTS_PER_LEVEL_DEF = 10;
  localparam int unsigned GAP_INIT_DEF         = 160;
  localparam int unsigned GAP_MIN_DEF          = 80;
  localparam int unsigned GAP_STEP_DEF         = 8;
  localparam int unsigned INVULN_TICKS_DEF     = 32;
  localparam int unsigned SCORE_MAX            = 9999;

endpackage

// File: rtl/game_ctrl_score_ctr.sv
// Score datapath: tick-to-point prescaler, saturating score, and
// per-level floor-spacing reduction clamped at the minimum gap.
module score_ctr
  import game_pkg::*;
#(
  parameter int unsigned TICKS_PER_POINT  = TICKS_PER_POINT_DEF,
  parameter int unsigned POINTS_PER_LEVEL = POINTS_PER_LEVEL_DEF,
  parameter int unsigned GAP_INIT         = GAP_INIT_DEF,
  parameter int unsigned GAP_MIN          = GAP_MIN_DEF,
  parameter int unsigned GAP_STEP         = GAP_STEP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        adv,
  output logic [13:0] score,
  output logic [8:0]  time_gap
);

  localparam int unsigned TW = $clog2(TICKS_PER_POINT + 1);
  localparam int unsigned LW = $clog2(POINTS_PER_LEVEL + 1);

  logic [TW-1:0] tick_cnt;
  logic [LW-1:0] lvl_cnt;
  logic [8:0]    gap_next;

  // Compare in 10 bits so GAP_MIN+GAP_STEP cannot wrap.
  always_comb begin
    gap_next = time_gap - 9'(GAP_STEP);
    if ({1'b0, time_gap} < 10'(GAP_MIN + GAP_STEP))
      gap_next = 9'(GAP_MIN);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tick_cnt <= '0;
      lvl_cnt  <= '0;
      score    <= '0;
      time_gap <= 9'(GAP_INIT);
    end else if (adv) begin
      if (tick_cnt == TW'(TICKS_PER_POINT - 1)) begin
        tick_cnt <= '0;
        if (score != 14'(SCORE_MAX)) begin
          score <= score + 14'd1;
          if (lvl_cnt == LW'(POINTS_PER_LEVEL - 1)) begin
            lvl_cnt  <= '0;
            time_gap <= gap_next;
          end else begin
            lvl_cnt <= lvl_cnt + LW'(1);
          end
        end
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game controller top: play/hurt/pause FSM, hazard handling, lives,
// invulnerability window and registered step/reinit pulses.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned LIVES_INIT       = LIVES_INIT_DEF,
  parameter int unsigned TICKS_PER_POINT  = TICKS_PER_POINT_DEF,
  parameter int unsigned POINTS_PER_LEVEL = POINTS_PER_LEVEL_DEF,
  parameter int unsigned GAP_INIT         = GAP_INIT_DEF,
  parameter int unsigned GAP_MIN          = GAP_MIN_DEF,
  parameter int unsigned GAP_STEP         = GAP_STEP_DEF,
  parameter int unsigned INVULN_TICKS     = INVULN_TICKS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start_key,
  input  logic        pause_key,
  input  logic        hit_ceiling,
  input  logic        fell_out,
  output logic [2:0]  state,
  output logic        step,
  output logic        reinit,
  output logic [1:0]  lives,
  output logic [13:0] score,
  output logic [8:0]  time_gap,
  output logic        blink
);

  localparam int unsigned IW_RAW = $clog2(INVULN_TICKS + 1);
  localparam int unsigned IW     = (IW_RAW < 3) ? 3 : IW_RAW;

  state_t        st, st_n;
  logic [1:0]    lives_n;
  logic [IW-1:0] inv, inv_n;
  logic          origin_hurt, origin_n;
  logic          step_n, reinit_n;
  logic          sc_clear, sc_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S_IDLE;
      lives       <= 2'(LIVES_INIT);
      inv         <= '0;
      origin_hurt <= 1'b0;
      step        <= 1'b0;
      reinit      <= 1'b0;
    end else begin
      st          <= st_n;
      lives       <= lives_n;
      inv         <= inv_n;
      origin_hurt <= origin_n;
      step        <= step_n;
      reinit      <= reinit_n;
    end
  end

  always_comb begin
    st_n     = st;
    lives_n  = lives;
    inv_n    = inv;
    origin_n = origin_hurt;
    step_n   = 1'b0;
    reinit_n = 1'b0;
    sc_clear = 1'b0;
    sc_adv   = 1'b0;
    unique case (st)
      S_IDLE, S_OVER: begin
        if (start_key) begin
          st_n     = S_PLAY;
          lives_n  = 2'(LIVES_INIT);
          inv_n    = '0;
          reinit_n = 1'b1;
          sc_clear = 1'b1;
        end
      end
      S_PLAY: begin
        // pause wins over a coincident tick: no step, no hazard sampling
        if (pause_key) begin
          st_n     = S_PAUSE;
          origin_n = 1'b0;
        end else if (tick) begin
          step_n = 1'b1;
          sc_adv = 1'b1;
          if (fell_out || (hit_ceiling && lives == 2'd1)) begin
            lives_n = '0;
            st_n    = S_OVER;
          end else if (hit_ceiling) begin
            lives_n = lives - 2'd1;
            inv_n   = IW'(INVULN_TICKS);
            st_n    = S_HURT;
          end
        end
      end
      S_HURT: begin
        if (pause_key) begin
          st_n     = S_PAUSE;
          origin_n = 1'b1;
        end else if (tick) begin
          step_n = 1'b1;
          sc_adv = 1'b1;
          if (fell_out) begin
            lives_n = '0;
            st_n    = S_OVER;
          end else if (inv <= IW'(1)) begin
            inv_n = '0;
            st_n  = S_PLAY;
          end else begin
            inv_n = inv - IW'(1);
          end
        end
      end
      S_PAUSE: begin
        if (pause_key)
          st_n = origin_hurt ? S_HURT : S_PLAY;
      end
      default: st_n = S_IDLE;
    endcase
  end

  score_ctr #(
    .TICKS_PER_POINT (TICKS_PER_POINT),
    .POINTS_PER_LEVEL(POINTS_PER_LEVEL),
    .GAP_INIT        (GAP_INIT),
    .GAP_MIN         (GAP_MIN),
    .GAP_STEP        (GAP_STEP)
  ) u_score (
    .clk     (clk),
    .rst     (rst),
    .clear   (sc_clear),
    .adv     (sc_adv),
    .score   (score),
    .time_gap(time_gap)
  );

  assign state = st;
  assign blink = (st == S_HURT) && inv[2];

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: a vector table for the basic FSM walk,
// then hand sequences for scoring, hurt window, pause, game over and reset.
module tb_game_ctrl;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst, tick, start_key, pause_key, hit_ceiling, fell_out;
  logic [2:0]  state, state2;
  logic        step, reinit, blink, step2, reinit2, blink2;
  logic [1:0]  lives, lives2;
  logic [13:0] score, score2;
  logic [8:0]  time_gap, time_gap2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  game_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .start_key(start_key),
    .pause_key(pause_key), .hit_ceiling(hit_ceiling), .fell_out(fell_out),
    .state(state), .step(step), .reinit(reinit), .lives(lives),
    .score(score), .time_gap(time_gap), .blink(blink)
  );

  // Fast-scoring instance with a gap step that does not divide the range.
  game_ctrl #(.TICKS_PER_POINT(1), .GAP_STEP(7)) dut2 (
    .clk(clk), .rst(rst), .tick(tick), .start_key(start_key),
    .pause_key(pause_key), .hit_ceiling(hit_ceiling), .fell_out(fell_out),
    .state(state2), .step(step2), .reinit(reinit2), .lives(lives2),
    .score(score2), .time_gap(time_gap2), .blink(blink2)
  );

  typedef struct {
    logic       tk, sk, pk, hc, fo;
    logic [2:0] e_state;
    logic       e_step, e_reinit, e_blink;
    logic [1:0] e_lives;
    int         e_score, e_gap;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic t, input logic s, input logic p);
    tick = t; start_key = s; pause_key = p;
    @(posedge clk); #1;
    tick = 1'b0; start_key = 1'b0; pause_key = 1'b0;
  endtask

  function automatic vec_t mk(input logic tk, sk, pk, hc, fo,
                              input state_t es, input logic est, erl,
                              input int elv, esc);
    vec_t v;
    v.tk = tk; v.sk = sk; v.pk = pk; v.hc = hc; v.fo = fo;
    v.e_state = es; v.e_step = est; v.e_reinit = erl; v.e_blink = 1'b0;
    v.e_lives = 2'(elv); v.e_score = esc; v.e_gap = 160;
    return v;
  endfunction

  int steps_ok, steps_bad, rises, sc_m, gap_m;
  logic prev_blink;

  initial begin
    rst = 1'b1; tick = 0; start_key = 0; pause_key = 0; hit_ceiling = 0; fell_out = 0;
    //            tk sk pk hc fo  state    step rei lives score
    vt[0]  = mk(0, 0, 1, 0, 0, S_IDLE,  0, 0, 3, 0);
    vt[1]  = mk(1, 0, 0, 0, 0, S_IDLE,  0, 0, 3, 0);
    vt[2]  = mk(0, 1, 0, 0, 0, S_PLAY,  0, 1, 3, 0);
    vt[3]  = mk(0, 0, 0, 0, 0, S_PLAY,  0, 0, 3, 0);
    vt[4]  = mk(0, 1, 0, 0, 0, S_PLAY,  0, 0, 3, 0);
    vt[5]  = mk(1, 0, 0, 0, 0, S_PLAY,  1, 0, 3, 0);
    vt[6]  = mk(0, 0, 0, 1, 0, S_PLAY,  0, 0, 3, 0);
    vt[7]  = mk(1, 0, 0, 1, 0, S_HURT,  1, 0, 2, 0);
    vt[8]  = mk(0, 0, 1, 0, 0, S_PAUSE, 0, 0, 2, 0);
    vt[9]  = mk(1, 0, 0, 0, 0, S_PAUSE, 0, 0, 2, 0);
    vt[10] = mk(1, 0, 0, 1, 1, S_PAUSE, 0, 0, 2, 0);
    vt[11] = mk(0, 1, 0, 0, 0, S_PAUSE, 0, 0, 2, 0);
    vt[12] = mk(0, 0, 1, 0, 0, S_HURT,  0, 0, 2, 0);
    vt[13] = mk(1, 0, 0, 0, 1, S_OVER,  1, 0, 0, 0);
    vt[14] = mk(1, 0, 0, 0, 0, S_OVER,  0, 0, 0, 0);
    vt[15] = mk(0, 0, 1, 0, 0, S_OVER,  0, 0, 0, 0);
    vt[16] = mk(0, 1, 0, 0, 0, S_PLAY,  0, 1, 3, 0);

    cyc(0, 0, 0); cyc(0, 0, 0);
    chk("rst_state", int'(state), int'(S_IDLE));
    chk("rst_step", int'(step), 0);
    chk("rst_reinit", int'(reinit), 0);
    chk("rst_blink", int'(blink), 0);
    chk("rst_lives", int'(lives), 3);
    chk("rst_score", int'(score), 0);
    chk("rst_gap", int'(time_gap), 160);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      hit_ceiling = vt[i].hc; fell_out = vt[i].fo;
      cyc(vt[i].tk, vt[i].sk, vt[i].pk);
      hit_ceiling = 0; fell_out = 0;
      chk($sformatf("vec%0d_state", i), int'(state), int'(vt[i].e_state));
      chk($sformatf("vec%0d_step", i), int'(step), int'(vt[i].e_step));
      chk($sformatf("vec%0d_reinit", i), int'(reinit), int'(vt[i].e_reinit));
      chk($sformatf("vec%0d_blink", i), int'(blink), int'(vt[i].e_blink));
      chk($sformatf("vec%0d_lives", i), int'(lives), int'(vt[i].e_lives));
      chk($sformatf("vec%0d_score", i), int'(score), vt[i].e_score);
      chk($sformatf("vec%0d_gap", i), int'(time_gap), vt[i].e_gap);
    end
    cyc(0, 0, 0);
    chk("reinit_one_cycle", int'(reinit), 0);

    // 640 ticks in PLAY, each followed by an idle cycle
    steps_ok = 0; steps_bad = 0;
    for (int i = 1; i <= 640; i++) begin
      cyc(1, 0, 0);
      if (step) steps_ok++;
      cyc(0, 0, 0);
      if (step) steps_bad++;
      if (i == 320) begin
        chk("half_score", int'(score), 5);
        chk("half_gap", int'(time_gap), 160);
      end
    end
    chk("step_count", steps_ok, 640);
    chk("step_misplaced", steps_bad, 0);
    chk("score_640", int'(score), 10);
    chk("gap_640", int'(time_gap), 152);

    // hit with lives=3, ceiling held through the whole window
    hit_ceiling = 1'b1;
    cyc(1, 0, 0);
    chk("hurt_enter_state", int'(state), int'(S_HURT));
    chk("hurt_enter_lives", int'(lives), 2);
    chk("hurt_enter_blink", int'(blink), 0);
    rises = 0; prev_blink = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      cyc(1, 0, 0);
      chk($sformatf("hurt_t%0d_lives", i), int'(lives), 2);
      if (i < 32) begin
        chk($sformatf("hurt_t%0d_state", i), int'(state), int'(S_HURT));
        chk($sformatf("hurt_t%0d_blink", i), int'(blink), ((32 - i) >> 2) & 1);
      end else begin
        chk("hurt_exit_state", int'(state), int'(S_PLAY));
        chk("hurt_exit_blink", int'(blink), 0);
      end
      if (blink && !prev_blink) rises++;
      prev_blink = blink;
    end
    hit_ceiling = 1'b0;
    chk("blink_rises", rises, 4);

    // second hit, then pause coincident with tick at counter 10
    hit_ceiling = 1'b1; cyc(1, 0, 0); hit_ceiling = 1'b0;
    chk("hit2_lives", int'(lives), 1);
    for (int i = 0; i < 22; i++) cyc(1, 0, 0);
    chk("pre_pause_state", int'(state), int'(S_HURT));
    hit_ceiling = 1'b1; fell_out = 1'b1;
    cyc(1, 0, 1);
    chk("pause_tick_state", int'(state), int'(S_PAUSE));
    chk("pause_tick_step", int'(step), 0);
    chk("pause_tick_lives", int'(lives), 1);
    steps_bad = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 0);
      if (step || state != 3'(S_PAUSE)) steps_bad++;
    end
    hit_ceiling = 1'b0; fell_out = 1'b0;
    chk("pause_ignored", steps_bad, 0);
    cyc(0, 0, 1);
    chk("unpause_state", int'(state), int'(S_HURT));
    for (int i = 0; i < 9; i++) cyc(1, 0, 0);
    chk("resume_t9_state", int'(state), int'(S_HURT));
    cyc(1, 0, 0);
    chk("resume_t10_state", int'(state), int'(S_PLAY));
    chk("resume_score", int'(score), 11);

    // ceiling hit on the last life
    hit_ceiling = 1'b1; cyc(1, 0, 0); hit_ceiling = 1'b0;
    chk("last_life_state", int'(state), int'(S_OVER));
    chk("last_life_lives", int'(lives), 0);
    cyc(1, 0, 0);
    chk("over_step", int'(step), 0);
    chk("over_score_hold", int'(score), 11);
    cyc(0, 1, 0);
    chk("restart_state", int'(state), int'(S_PLAY));
    chk("restart_reinit", int'(reinit), 1);
    chk("restart_lives", int'(lives), 3);
    chk("restart_score", int'(score), 0);

    // fell_out beats hit_ceiling
    hit_ceiling = 1'b1; fell_out = 1'b1; cyc(1, 0, 0);
    hit_ceiling = 1'b0; fell_out = 1'b0;
    chk("both_state", int'(state), int'(S_OVER));
    chk("both_lives", int'(lives), 0);
    cyc(0, 1, 0);
    chk("both_restart_state", int'(state), int'(S_PLAY));
    chk("both_restart_lives", int'(lives), 3);
    chk("both_restart_score", int'(score), 0);

    // reset in the middle of HURT
    hit_ceiling = 1'b1; cyc(1, 0, 0); hit_ceiling = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    chk("pre_rst_state", int'(state), int'(S_HURT));
    rst = 1'b1;
    cyc(1, 1, 0);
    chk("midrst_state", int'(state), int'(S_IDLE));
    chk("midrst_step", int'(step), 0);
    chk("midrst_reinit", int'(reinit), 0);
    chk("midrst_lives", int'(lives), 3);
    chk("midrst_blink", int'(blink), 0);
    chk("midrst_score", int'(score), 0);
    rst = 1'b0;
    cyc(1, 0, 0);
    chk("postrst_step", int'(step), 0);
    chk("postrst_reinit", int'(reinit), 0);

    // dut2: score saturation and gap clamping, one point per tick
    rst = 1'b1; cyc(0, 0, 0); rst = 1'b0;
    cyc(0, 1, 0);
    chk("d2_start_state", int'(state2), int'(S_PLAY));
    steps_bad = 0;
    for (int i = 1; i <= 9999 + 64; i++) begin
      cyc(1, 0, 0);
      sc_m  = (i > 9999) ? 9999 : i;
      gap_m = 160 - 7 * (sc_m / 10);
      if (gap_m < 80) gap_m = 80;
      if (int'(score2) != sc_m || int'(time_gap2) != gap_m) steps_bad++;
      if (i == 9999 + 64 || (i % 1000) == 0) begin
        chk($sformatf("d2_score_%0d", i), int'(score2), sc_m);
        chk($sformatf("d2_gap_%0d", i), int'(time_gap2), gap_m);
      end
    end
    chk("d2_track_errors", steps_bad, 0);
    chk("d2_final_score", int'(score2), 9999);
    chk("d2_final_gap", int'(time_gap2), 80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- LIVES_INIT, 3, lives loaded at game start (1..3).
- TICKS_PER_POINT, 64, game ticks per score point.
- POINTS_PER_LEVEL, 10, score points per difficulty step.
- GAP_INIT, 160, initial floor spacing.
- GAP_MIN, 80, floor spacing lower bound.
- GAP_STEP, 8, spacing decrement per level.
- INVULN_TICKS, 32, post-hit invulnerability length in ticks.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- tick, in, 1, one-cycle game-tick pulse (clk domain).
- start_key, in, 1, one-cycle start pulse.
- pause_key, in, 1, one-cycle pause-toggle pulse.
- hit_ceiling, in, 1, level; slime touches ceiling spikes.
- fell_out, in, 1, level; slime below the screen bottom.
- state, out, 3, current FSM state encoding.
- step, out, 1, one-cycle advance pulse to floor_gen and slime_move.
- reinit, out, 1, one-cycle datapath re-initialise pulse.
- lives, out, 2, remaining lives.
- score, out, 14, binary score, 0..9999.
- time_gap, out, 9, floor spacing to floor_gen.
- blink, out, 1, slime flash enable for pixel_gen.

Function
REQ-003 FSM states SHALL be IDLE, PLAY, HURT, PAUSE, OVER.
REQ-004 IDLE: start_key SHALL move to PLAY, pulse reinit for exactly 1 cycle, and load score=0, lives=LIVES_INIT, time_gap=GAP_INIT, tick counter=0.
REQ-005 step SHALL be registered: asserted the cycle after a tick that is sampled in PLAY or HURT; otherwise 0.
REQ-006 PLAY/HURT: each tick SHALL increment the tick counter; on reaching TICKS_PER_POINT the counter SHALL clear and score SHALL increment, saturating at 9999.
REQ-007 Every POINTS_PER_LEVEL score increments, time_gap SHALL decrease by GAP_STEP, never below GAP_MIN; a decrement that would cross GAP_MIN SHALL clamp to GAP_MIN.
REQ-008 Hazards SHALL be sampled only on tick cycles.
REQ-009 PLAY hazard handling:
- fell_out: lives:=0, go to OVER.
- Else hit_ceiling with lives==1: lives:=0, go to OVER.
- Else hit_ceiling: lives-1, load invulnerability counter with INVULN_TICKS, go to HURT.
REQ-010 fell_out SHALL take priority over hit_ceiling in the same tick.
REQ-011 HURT: hit_ceiling SHALL be ignored; fell_out SHALL behave as in PLAY. The counter SHALL decrement per tick; on reaching 0, return to PLAY.
REQ-012 blink SHALL equal (state==HURT) AND invulnerability counter bit 2; otherwise 0.
REQ-013 pause_key in PLAY or HURT SHALL enter PAUSE and record the origin state. In PAUSE, pause_key SHALL return to the origin with all counters intact.
REQ-014 In PAUSE, tick, start_key and hazards SHALL be ignored, and step SHALL be 0.
REQ-015 pause_key coincident with tick in PLAY/HURT SHALL win: enter PAUSE, do not step, do not sample hazards.
REQ-016 OVER: step SHALL be 0 and score/lives SHALL hold. start_key SHALL restart exactly as in REQ-004.
REQ-017 start_key SHALL be ignored in PLAY, HURT and PAUSE. pause_key SHALL be ignored in IDLE and OVER.

Reset
REQ-018 On rst, at the next clk edge: state=IDLE, step=0, reinit=0, blink=0, lives=LIVES_INIT, score=0, time_gap=GAP_INIT, all counters 0.
REQ-019 rst asserted mid-game SHALL abandon the game with no step or reinit pulse issued during or in the cycle after reset.

Structure
REQ-020 A shared package game_pkg SHALL hold the state enumeration, the parameter defaults and the SCORE_MAX=9999 constant.
REQ-021 Score, level and gap arithmetic SHALL live in one sub-module, score_ctr. game_ctrl keeps the FSM, hazard logic and step/reinit generation.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, then start_key -> reinit high 1 cycle; state PLAY; lives=3; score=0; time_gap=160.
- 640 ticks in PLAY -> score=10, time_gap=152; step count=640, each step 1 cycle after its tick.
- hit_ceiling on a tick with lives=3 -> HURT, lives=2, blink toggles; hit_ceiling held for 32 ticks -> no further loss; PLAY after tick 32.
- hit_ceiling and fell_out on the same tick with lives=3 -> OVER, lives=0; start_key -> PLAY, lives=3, score=0.
- pause_key coincident with tick in HURT, counter=10 -> PAUSE, no step; 5 ticks ignored; pause_key -> HURT, counter still 10.
- Score preset to 9999 then 64 ticks -> score stays 9999; time_gap never below 80; rst mid-HURT -> IDLE next edge.
